dds_sweep_ctrl: RTL and testbench

//  Frequency-sweep scheduler for the DDS core. Sits between the UART command decoder and the
//  DDS phase accumulator: latches sweep config (start/stop/step/dwell/mode), then steps

---
 rtl/dds_sweep_ctrl_pkg.sv | 19 +
 rtl/dds_sweep_ctrl_if.sv | 34 +++
 rtl/dds_sweep_ctrl_dwell_timer.sv | 30 +++
 rtl/dds_sweep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared constants and types for the DDS frequency-sweep scheduler.
package dds_sweep_ctrl_pkg;

    localparam int P_FREQ_W       = 26;
    localparam int P_DWELL_W      = 24;
    localparam int P_FREQ_DEFAULT = 1000;

    // 2'b11 is decoded as single-up, same as MODE_SINGLE
    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config/control/status bundle between the command decoder and the sweep scheduler.
interface dds_sweep_ctrl_if
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int FREQ_W  = P_FREQ_W,
    parameter int DWELL_W = P_DWELL_W
);
    logic               cfg_load;
    logic [FREQ_W-1:0]  cfg_start_freq;
    logic [FREQ_W-1:0]  cfg_stop_freq;
    logic [FREQ_W-1:0]  cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic [FREQ_W-1:0]  freq_ctrl;
    logic               freq_valid;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode,
               start, abort,
        input  freq_ctrl, freq_valid, busy, done, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_start_freq, cfg_stop_freq, cfg_step, cfg_dwell, cfg_mode,
               start, abort,
        output freq_ctrl, freq_valid, busy, done, cfg_err
    );

endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Per-point dwell down-counter; expire fires on the last cycle of the point.
module dds_dwell_timer
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_W = P_DWELL_W
) (
    input  logic               sys_clk_50M,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_val,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_cnt;

    // A dwell of zero would never expire, so it is held for one cycle instead
    always_ff @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_val == '0) ? DWELL_W'(1) : i_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == DWELL_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep scheduler: shadow/working config, IDLE/UP/DOWN FSM and saturating next-point math.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int FREQ_W       = P_FREQ_W,
    parameter int DWELL_W      = P_DWELL_W,
    parameter int FREQ_DEFAULT = P_FREQ_DEFAULT
) (
    input logic             sys_clk_50M,
    input logic             rst_n,
    dds_sweep_ctrl_if.slave bus
);

    state_t             r_state, w_state_nxt;
    logic [FREQ_W-1:0]  r_freq, w_freq_nxt;
    logic               r_valid, r_done, r_err;
    logic               w_issue, w_done_nxt, w_err_nxt, w_accept;
    logic               w_busy, w_expire, w_tmr_load, w_tmr_en;
    logic [DWELL_W-1:0] w_tmr_val;
    logic [FREQ_W-1:0]  w_up, w_dn;
    logic               w_sh_bad;

    logic [FREQ_W-1:0]  r_sh_start, r_sh_stop, r_sh_step;
    logic [DWELL_W-1:0] r_sh_dwell;
    logic [1:0]         r_sh_mode;
    logic [FREQ_W-1:0]  r_wk_start, r_wk_stop, r_wk_step;
    logic [DWELL_W-1:0] r_wk_dwell;
    logic [1:0]         r_wk_mode;

    // One extra bit on both sides so the sweep clamps instead of wrapping at 2^FREQ_W
    function automatic logic [FREQ_W-1:0] sat_add(input logic [FREQ_W-1:0] a, b, lim);
        logic [FREQ_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[FREQ_W-1:0];
    endfunction

    function automatic logic [FREQ_W-1:0] sat_sub(input logic [FREQ_W-1:0] a, b, lim);
        logic [FREQ_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return (d[FREQ_W] || (d[FREQ_W-1:0] < lim)) ? lim : d[FREQ_W-1:0];
    endfunction

    assign w_up     = sat_add(r_freq, r_wk_step, r_wk_stop);
    assign w_dn     = sat_sub(r_freq, r_wk_step, r_wk_start);
    assign w_sh_bad = (r_sh_step == '0) || (r_sh_start > r_sh_stop);

    always_ff @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_issue     = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_accept    = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_sh_bad) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_accept    = 1'b1;
                            w_issue     = 1'b1;
                            w_state_nxt = ST_UP;
                            w_freq_nxt  = r_sh_start;
                        end
                    end
                end
                ST_UP: begin
                    if (w_expire) begin
                        if (r_freq == r_wk_stop) begin
                            case (r_wk_mode)
                                MODE_SAW: begin
                                    w_issue    = 1'b1;
                                    w_freq_nxt = r_wk_start;
                                end
                                MODE_TRI: begin
                                    w_issue     = 1'b1;
                                    w_state_nxt = ST_DOWN;
                                    w_freq_nxt  = w_dn;
                                end
                                default: begin
                                    w_state_nxt = ST_IDLE;
                                    w_done_nxt  = 1'b1;
                                end
                            endcase
                        end else begin
                            w_issue    = 1'b1;
                            w_freq_nxt = w_up;
                        end
                    end
                end
                ST_DOWN: begin
                    if (w_expire) begin
                        w_issue = 1'b1;
                        if (r_freq == r_wk_start) begin
                            w_state_nxt = ST_UP;
                            w_freq_nxt  = w_up;
                        end else begin
                            w_freq_nxt  = w_dn;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_tmr_en   = w_busy;
        w_tmr_load = w_issue;
        w_tmr_val  = w_accept ? r_sh_dwell : r_wk_dwell;
    end

    // Working copy is taken from the pre-load shadow, so a same-cycle cfg_load only affects later starts
    always_ff @(posedge sys_clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_freq     <= FREQ_W'(FREQ_DEFAULT);
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sh_start <= FREQ_W'(FREQ_DEFAULT);
            r_sh_stop  <= FREQ_W'(FREQ_DEFAULT);
            r_sh_step  <= FREQ_W'(1);
            r_sh_dwell <= DWELL_W'(1);
            r_sh_mode  <= MODE_SINGLE;
            r_wk_start <= FREQ_W'(FREQ_DEFAULT);
            r_wk_stop  <= FREQ_W'(FREQ_DEFAULT);
            r_wk_step  <= FREQ_W'(1);
            r_wk_dwell <= DWELL_W'(1);
            r_wk_mode  <= MODE_SINGLE;
        end else begin
            r_freq  <= w_freq_nxt;
            r_valid <= w_issue;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (bus.cfg_load) begin
                r_sh_start <= bus.cfg_start_freq;
                r_sh_stop  <= bus.cfg_stop_freq;
                r_sh_step  <= bus.cfg_step;
                r_sh_dwell <= bus.cfg_dwell;
                r_sh_mode  <= bus.cfg_mode;
            end
            if (w_accept) begin
                r_wk_start <= r_sh_start;
                r_wk_stop  <= r_sh_stop;
                r_wk_step  <= r_sh_step;
                r_wk_dwell <= r_sh_dwell;
                r_wk_mode  <= r_sh_mode;
            end
        end
    end

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .sys_clk_50M (sys_clk_50M),
        .rst_n       (rst_n),
        .i_load      (w_tmr_load),
        .i_en        (w_tmr_en),
        .i_val       (w_tmr_val),
        .o_expire    (w_expire)
    );

    assign bus.freq_ctrl  = r_freq;
    assign bus.freq_valid = r_valid;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.cfg_err    = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed sweep sequences checked by immediate assertions.
module tb_dds_sweep_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_vld;
    int   n_done;

    dds_sweep_ctrl_if #(.FREQ_W(26), .DWELL_W(24)) bus ();

    dds_sweep_ctrl dut (
        .sys_clk_50M (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int s, input int e, input int st, input int dw, input int md);
        bus.cfg_start_freq = 26'(s);
        bus.cfg_stop_freq  = 26'(e);
        bus.cfg_step       = 26'(st);
        bus.cfg_dwell      = 24'(dw);
        bus.cfg_mode       = 2'(md);
        bus.cfg_load       = 1'b1;
        tick();
        bus.cfg_load       = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        int tri_seq [9];
        int top_seq [6];
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.cfg_load = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.cfg_start_freq = '0; bus.cfg_stop_freq = '0; bus.cfg_step = '0;
        bus.cfg_dwell = '0; bus.cfg_mode = '0;
        #45;
        chk("rst_freq", 32'(bus.freq_ctrl), 1000);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_flags", {29'd0, bus.freq_valid, bus.done, bus.cfg_err}, 0);
        rst_n = 1'b1;

        // 1: idle after reset
        n_vld = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_vld += int'(bus.freq_valid);
        end
        chk("idle_valid_cnt", 32'(n_vld), 0);
        chk("idle_freq", 32'(bus.freq_ctrl), 1000);

        // 2: single-up 100..130 step 10 dwell 3
        load_cfg(100, 130, 10, 3, 0);
        pulse_start();
        chk("s_first", 32'(bus.freq_ctrl), 100);
        chk("s_busy", 32'(bus.busy), 1);
        n_vld = int'(bus.freq_valid);
        n_done = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vld  += int'(bus.freq_valid);
            n_done += int'(bus.done);
            if (k == 3) chk("s_p1", 32'(bus.freq_ctrl), 110);
            if (k == 6) chk("s_p2", 32'(bus.freq_ctrl), 120);
            if (k == 9) chk("s_p3", 32'(bus.freq_ctrl), 130);
        end
        chk("s_done", 32'(bus.done), 1);
        chk("s_busy_end", 32'(bus.busy), 0);
        chk("s_vld_cnt", 32'(n_vld), 4);
        tick();
        n_done += int'(bus.done);
        chk("s_done_cnt", 32'(n_done), 1);
        chk("s_hold", 32'(bus.freq_ctrl), 130);

        // 3: triangle 0..20 step 8 dwell 1
        tri_seq = '{0, 8, 16, 20, 12, 4, 0, 8, 16};
        load_cfg(0, 20, 8, 1, 2);
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            chk($sformatf("tri_%0d", k), 32'(bus.freq_ctrl), 32'(tri_seq[k]));
            chk($sformatf("tri_v%0d", k), 32'(bus.freq_valid), 1);
        end
        pulse_abort();
        chk("tri_abort_busy", 32'(bus.busy), 0);
        chk("tri_abort_freq", 32'(bus.freq_ctrl), 16);
        chk("tri_abort_flags", {30'd0, bus.freq_valid, bus.done}, 0);

        // 4: rejected starts
        load_cfg(50, 60, 0, 1, 0);
        pulse_start();
        chk("err_step0", 32'(bus.cfg_err), 1);
        chk("err_step0_busy", 32'(bus.busy), 0);
        chk("err_step0_freq", 32'(bus.freq_ctrl), 16);
        tick();
        chk("err_pulse_len", 32'(bus.cfg_err), 0);
        load_cfg(50, 40, 1, 1, 0);
        pulse_start();
        chk("err_order", 32'(bus.cfg_err), 1);
        chk("err_order_freq", 32'(bus.freq_ctrl), 16);
        load_cfg(50, 60, 1, 1, 0);
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_start_err", 32'(bus.cfg_err), 0);
        chk("abort_start_busy", 32'(bus.busy), 0);

        // 5: saw with mid-sweep reload, abort at 120
        load_cfg(100, 130, 10, 2, 1);
        pulse_start();
        chk("saw_first", 32'(bus.freq_ctrl), 100);
        load_cfg(200, 230, 5, 1, 0);
        chk("saw_k1", 32'(bus.freq_ctrl), 100);
        tick(); tick(); tick();
        chk("saw_k4", 32'(bus.freq_ctrl), 120);
        pulse_abort();
        chk("saw_abort_busy", 32'(bus.busy), 0);
        chk("saw_abort_freq", 32'(bus.freq_ctrl), 120);
        chk("saw_abort_done", 32'(bus.done), 0);
        pulse_start();
        chk("new_cfg_first", 32'(bus.freq_ctrl), 200);
        tick();
        chk("new_cfg_second", 32'(bus.freq_ctrl), 205);
        pulse_abort();

        // saw wrap back to start, with start ignored while busy
        load_cfg(10, 20, 10, 1, 1);
        pulse_start();
        chk("wrap_0", 32'(bus.freq_ctrl), 10);
        pulse_start();
        chk("wrap_1", 32'(bus.freq_ctrl), 20);
        chk("busy_start_err", 32'(bus.cfg_err), 0);
        tick();
        chk("wrap_2", 32'(bus.freq_ctrl), 10);
        chk("wrap_2v", 32'(bus.freq_valid), 1);
        pulse_abort();

        // start==stop single with dwell 0 treated as 1
        load_cfg(500, 500, 1, 0, 3);
        pulse_start();
        chk("one_pt", 32'(bus.freq_ctrl), 500);
        tick();
        chk("one_pt_done", 32'(bus.done), 1);
        chk("one_pt_vld", 32'(bus.freq_valid), 0);

        // 6: triangle near top of range, no wrap
        top_seq = '{67108854, 67108862, 67108863, 67108855, 67108854, 67108862};
        load_cfg(67108854, 67108863, 8, 1, 2);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            chk($sformatf("top_%0d", k), 32'(bus.freq_ctrl), 32'(top_seq[k]));
        end

        // reset mid-sweep
        rst_n = 1'b0;
        #3;
        chk("midrst_freq", 32'(bus.freq_ctrl), 1000);
        chk("midrst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", 32'(bus.freq_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
